data_mem_ctrl: RTL

// Parametrised, handshaked data memory. It is the next-generation replacement for the

---
 rtl/data_mem_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Handshaked byte/half/word data memory with programmable access latency.
// Rejects misaligned, out-of-range and illegal-size accesses without touching the array.
module data_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  if ((LATENCY < 1) || (LATENCY > 7)) begin : g_bad_latency
    $error("data_mem_ctrl: LATENCY must be in 1..7");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_next;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [0:DEPTH_WORDS-1];

  logic              w_accept;
  logic              w_exec;
  logic              w_wr_en;
  logic [ADDR_W-3:0] w_word_idx;
  logic [IDX_W-1:0]  w_mem_idx;
  logic              w_in_range;
  logic              w_err;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_lane_data;
  logic [31:0]       w_load_data;
  logic [31:0]       w_rsp_data;
  logic [3:0]        w_wmask;
  logic [31:0]       w_wdata_lanes;

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  assign w_exec     = (r_state == S_WAIT) && (r_cnt == 3'd0);
  assign w_word_idx = r_addr[ADDR_W-1:2];
  assign w_mem_idx  = w_word_idx[IDX_W-1:0];
  assign w_in_range = (w_word_idx < DEPTH_L);
  // rst_n gating keeps a store aborted in its execute cycle out of the array
  assign w_wr_en    = w_exec && r_we && !w_err && rst_n;

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // next-state and latency counter
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next_state = S_WAIT;
          w_cnt_next   = CNT_INIT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_next_state = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // access checks; out-of-range words are never used to index the array
  always_comb begin
    case (r_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = r_addr[0];
      2'b10:   w_err = |r_addr[1:0];
      default: w_err = 1'b1;
    endcase
    if (!w_in_range) begin
      w_err = 1'b1;
    end else begin
      w_err = w_err;
    end
    if (w_in_range) begin
      w_rd_word = r_mem[w_mem_idx];
    end else begin
      w_rd_word = 32'h0000_0000;
    end
  end

  // load alignment/extension and store lane steering
  always_comb begin
    w_lane_data = w_rd_word >> {r_addr[1:0], 3'b000};
    case (r_size)
      2'b00: begin
        w_load_data   = r_unsigned ? {24'h00_0000, w_lane_data[7:0]}
                                   : {{24{w_lane_data[7]}}, w_lane_data[7:0]};
        w_wmask       = 4'b0001 << r_addr[1:0];
        w_wdata_lanes = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_load_data   = r_unsigned ? {16'h0000, w_lane_data[15:0]}
                                   : {{16{w_lane_data[15]}}, w_lane_data[15:0]};
        w_wmask       = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata_lanes = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_load_data   = w_rd_word;
        w_wmask       = 4'b1111;
        w_wdata_lanes = r_wdata;
      end
      default: begin
        w_load_data   = 32'h0000_0000;
        w_wmask       = 4'b0000;
        w_wdata_lanes = 32'h0000_0000;
      end
    endcase
    if (w_err || r_we) begin
      w_rsp_data = 32'h0000_0000;
    end else begin
      w_rsp_data = w_load_data;
    end
  end

  // state, handshake and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_cnt_next;
      r_req_ready <= (w_next_state == S_IDLE);
      r_rsp_valid <= (w_next_state == S_RESP);
      if (w_exec) begin
        r_rsp_rdata <= w_rsp_data;
        r_rsp_err   <= w_err;
      end
    end
  end

  // request capture on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0000_0000;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  // word array with per-byte write enables; deliberately not reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) begin
          r_mem[w_mem_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
        end
      end
    end
  end

endmodule
